// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
// State and phase encodings used by the top-level FSM.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RINGING = 2'd2,
      DONE    = 2'd3
   } state_e;

   typedef enum logic {
      PH_ON  = 1'b0,
      PH_OFF = 1'b1
   } phase_e;

   localparam int NUM_TONES_DEF = 5;
   localparam int TONE_W        = 3;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Event inputs and audio-control outputs of the alarm sequencer.
// master drives events and observes outputs; slave is the sequencer.
interface alarm_sequencer_if;
   import alarm_pkg::*;

   logic              start;
   logic              timer_zero;
   logic              stop_btn;
   logic              mic_trigger;
   logic              tone_btn;
   logic              endtime;
   logic              endsound;
   logic [TONE_W-1:0] audioselection;
   logic              alarm_led;

   modport master (
      output start,
      output timer_zero,
      output stop_btn,
      output mic_trigger,
      output tone_btn,
      input  endtime,
      input  endsound,
      input  audioselection,
      input  alarm_led
   );

   modport slave (
      input  start,
      input  timer_zero,
      input  stop_btn,
      input  mic_trigger,
      input  tone_btn,
      output endtime,
      output endsound,
      output audioselection,
      output alarm_led
   );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every DIV clocks.
// A synchronous clear restarts the count so the next tick is DIV cycles out.
module ms_tick_gen #(
   parameter int DIV = 5000
) (
   input  logic pulse_5MHz,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || tick)
         cnt_d = '0;
   end

   always_ff @(posedge pulse_5MHz) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm control stage: rings a gated beep pattern when the countdown
// reaches 00:00 and holds the user tone selection.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int TICK_DIV    = 5000,
   parameter int BEEP_ON_MS  = 500,
   parameter int BEEP_OFF_MS = 250,
   parameter int MAX_BEEPS   = 20,
   parameter int NUM_TONES   = NUM_TONES_DEF
) (
   input  logic               pulse_5MHz,
   input  logic               reset,
   alarm_sequencer_if.slave   bus
);

   localparam int MS_W   = $clog2(max2(BEEP_ON_MS, BEEP_OFF_MS) + 1);
   localparam int BEEP_W = $clog2(MAX_BEEPS + 1);

   state_e            state_q, state_d;
   phase_e            phase_q, phase_d;
   logic [MS_W-1:0]   ms_q, ms_d;
   logic [BEEP_W-1:0] beep_q, beep_d;
   logic [BEEP_W-1:0] beep_inc;
   logic [MS_W-1:0]   ms_last;
   logic [TONE_W-1:0] tone_q, tone_d;
   logic              tz_prev_q;
   logic              tz_edge;
   logic              silence;
   logic              tick;
   logic              tick_clr;
   logic              endtime_q, endtime_d;
   logic              endsound_q, endsound_d;
   logic              led_q, led_d;

   ms_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick (
      .pulse_5MHz (pulse_5MHz),
      .reset      (reset),
      .clear      (tick_clr),
      .tick       (tick)
   );

   assign tz_edge  = bus.timer_zero & ~tz_prev_q;
   assign silence  = bus.stop_btn | bus.mic_trigger;
   assign beep_inc = beep_q + BEEP_W'(1);
   assign ms_last  = (phase_q == PH_ON) ? MS_W'(BEEP_ON_MS - 1)
                                        : MS_W'(BEEP_OFF_MS - 1);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      ms_d     = ms_q;
      beep_d   = beep_q;
      tick_clr = 1'b0;
      if (bus.start) begin
         state_d = ARMED;
         phase_d = PH_ON;
         ms_d    = '0;
         beep_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED: begin
               if (silence) begin
                  state_d = IDLE;
               end else if (tz_edge) begin
                  state_d  = RINGING;
                  phase_d  = PH_ON;
                  ms_d     = '0;
                  beep_d   = '0;
                  tick_clr = 1'b1;
               end
            end
            RINGING: begin
               if (silence) begin
                  state_d = DONE;
               end else if (tick) begin
                  if (ms_q != ms_last) begin
                     ms_d = ms_q + MS_W'(1);
                  end else begin
                     ms_d = '0;
                     if (phase_q == PH_ON) begin
                        phase_d = PH_OFF;
                     end else begin
                        beep_d  = beep_inc;
                        phase_d = PH_ON;
                        if (beep_inc == BEEP_W'(MAX_BEEPS))
                           state_d = DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (bus.stop_btn)
                  state_d = IDLE;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so they track state_q.
   always_comb begin
      endtime_d  = (state_d == RINGING) || (state_d == DONE);
      endsound_d = ((state_d == RINGING) && (phase_d == PH_OFF))
                || (state_d == DONE);
      led_d      = (state_d == RINGING);
      tone_d     = tone_q;
      if (bus.tone_btn)
         tone_d = (tone_q == TONE_W'(NUM_TONES - 1)) ? '0
                                                     : tone_q + TONE_W'(1);
   end

   always_ff @(posedge pulse_5MHz) begin
      if (!reset) begin
         state_q    <= IDLE;
         phase_q    <= PH_ON;
         ms_q       <= '0;
         beep_q     <= '0;
         tone_q     <= '0;
         tz_prev_q  <= 1'b0;
         endtime_q  <= 1'b0;
         endsound_q <= 1'b0;
         led_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         ms_q       <= ms_d;
         beep_q     <= beep_d;
         tone_q     <= tone_d;
         tz_prev_q  <= bus.timer_zero;
         endtime_q  <= endtime_d;
         endsound_q <= endsound_d;
         led_q      <= led_d;
      end
   end

   assign bus.endtime        = endtime_q;
   assign bus.endsound       = endsound_q;
   assign bus.alarm_led      = led_q;
   assign bus.audioselection = tone_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a shortened timebase.
// Table vectors plus hand sequences for the multi-cycle ring patterns.
module tb_alarm_sequencer;

   localparam int TICK_DIV = 4;
   localparam int ON_MS    = 3;
   localparam int OFF_MS   = 2;
   localparam int MAXB     = 2;
   localparam int ON_CYC   = ON_MS * TICK_DIV;
   localparam int OFF_CYC  = OFF_MS * TICK_DIV;
   localparam int NV       = 18;

   typedef struct {
      logic       start;
      logic       tz;
      logic       stop;
      logic       mic;
      logic       tone;
      logic       et;
      logic       es;
      logic       led;
      logic [2:0] sel;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   alarm_sequencer_if bus ();

   alarm_sequencer #(
      .TICK_DIV    (TICK_DIV),
      .BEEP_ON_MS  (ON_MS),
      .BEEP_OFF_MS (OFF_MS),
      .MAX_BEEPS   (MAXB),
      .NUM_TONES   (5)
   ) dut (
      .pulse_5MHz (clk),
      .reset      (rst_n),
      .bus        (bus)
   );

   function automatic vec_t mk(input logic s, input logic z, input logic p,
                               input logic m, input logic t, input logic et,
                               input logic es, input logic led,
                               input logic [2:0] sel);
      vec_t v;
      v.start = s; v.tz = z; v.stop = p; v.mic = m; v.tone = t;
      v.et = et; v.es = es; v.led = led; v.sel = sel;
      return v;
   endfunction

   task automatic drive(input logic s, input logic z, input logic p,
                        input logic m, input logic t);
      bus.start       = s;
      bus.timer_zero  = z;
      bus.stop_btn    = p;
      bus.mic_trigger = m;
      bus.tone_btn    = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic et, input logic es,
                      input logic led, input logic [2:0] sel);
      checks++;
      if (bus.endtime !== et || bus.endsound !== es ||
          bus.alarm_led !== led || bus.audioselection !== sel) begin
         errors++;
         $display("FAIL %s: got et=%b es=%b led=%b sel=%0d, expected et=%b es=%b led=%b sel=%0d",
                  nm, bus.endtime, bus.endsound, bus.alarm_led,
                  bus.audioselection, et, es, led, sel);
      end
   endtask

   // Check a full ring from the first ON cycle through to DONE.
   task automatic ring_pattern(input string tag, input logic [2:0] sel);
      for (int b = 0; b < MAXB; b++) begin
         for (int i = 0; i < ON_CYC; i++) begin
            chk($sformatf("%s_on%0d_c%0d", tag, b, i), 1'b1, 1'b0, 1'b1, sel);
            step();
         end
         for (int i = 0; i < OFF_CYC; i++) begin
            chk($sformatf("%s_off%0d_c%0d", tag, b, i), 1'b1, 1'b1, 1'b1, sel);
            step();
         end
      end
      chk({tag, "_done"}, 1'b1, 1'b1, 1'b0, sel);
      step();
      chk({tag, "_done_hold"}, 1'b1, 1'b1, 1'b0, sel);
   endtask

   initial begin
      vecs[0]  = mk(0,0,0,0,1, 0,0,0, 3'd1);
      vecs[1]  = mk(0,0,0,0,1, 0,0,0, 3'd2);
      vecs[2]  = mk(0,0,0,0,1, 0,0,0, 3'd3);
      vecs[3]  = mk(0,0,0,0,1, 0,0,0, 3'd4);
      vecs[4]  = mk(0,0,0,0,1, 0,0,0, 3'd0);
      vecs[5]  = mk(0,0,0,0,1, 0,0,0, 3'd1);
      vecs[6]  = mk(0,1,0,0,0, 0,0,0, 3'd1);
      vecs[7]  = mk(1,1,0,0,0, 0,0,0, 3'd1);
      vecs[8]  = mk(0,1,0,0,0, 0,0,0, 3'd1);
      vecs[9]  = mk(0,1,0,0,0, 0,0,0, 3'd1);
      vecs[10] = mk(0,0,1,0,0, 0,0,0, 3'd1);
      vecs[11] = mk(0,1,0,0,0, 0,0,0, 3'd1);
      vecs[12] = mk(1,0,1,0,0, 0,0,0, 3'd1);
      vecs[13] = mk(0,1,0,0,0, 1,0,1, 3'd1);
      vecs[14] = mk(0,1,1,0,0, 1,1,0, 3'd1);
      vecs[15] = mk(0,0,0,0,1, 1,1,0, 3'd2);
      vecs[16] = mk(0,0,1,0,0, 0,0,0, 3'd2);
      vecs[17] = mk(0,0,1,0,1, 0,0,0, 3'd3);

      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (3) step();
      chk("reset_held", 1'b0, 1'b0, 1'b0, 3'd0);
      rst_n = 1'b1;
      step();
      chk("reset_release", 1'b0, 1'b0, 1'b0, 3'd0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].start, vecs[i].tz, vecs[i].stop, vecs[i].mic,
               vecs[i].tone);
         step();
         chk($sformatf("vec%0d", i), vecs[i].et, vecs[i].es, vecs[i].led,
             vecs[i].sel);
      end

      // Full ring to automatic silence.
      drive(1, 0, 0, 0, 0);
      step();
      chk("a_armed", 1'b0, 1'b0, 1'b0, 3'd3);
      drive(0, 1, 0, 0, 0);
      step();
      ring_pattern("a", 3'd3);
      drive(0, 1, 1, 0, 0);
      step();
      chk("a_stop_idle", 1'b0, 1'b0, 1'b0, 3'd3);

      // Clap on the second ON cycle.
      drive(1, 0, 0, 0, 0);
      step();
      chk("b_armed", 1'b0, 1'b0, 1'b0, 3'd3);
      drive(0, 1, 0, 0, 0);
      step();
      chk("b_on0", 1'b1, 1'b0, 1'b1, 3'd3);
      drive(0, 1, 0, 1, 0);
      step();
      chk("b_mic_done", 1'b1, 1'b1, 1'b0, 3'd3);
      drive(0, 1, 1, 0, 0);
      step();
      chk("b_stop_idle", 1'b0, 1'b0, 1'b0, 3'd3);

      // Restart during the second OFF gap; beep count must restart.
      drive(1, 0, 0, 0, 0);
      step();
      drive(0, 1, 0, 0, 0);
      step();
      chk("c_on0", 1'b1, 1'b0, 1'b1, 3'd3);
      repeat (ON_CYC) step();
      chk("c_off0_first", 1'b1, 1'b1, 1'b1, 3'd3);
      repeat (OFF_CYC + ON_CYC + 3) step();
      chk("c_off1_mid", 1'b1, 1'b1, 1'b1, 3'd3);
      drive(1, 1, 0, 0, 0);
      step();
      chk("c_restart_armed", 1'b0, 1'b0, 1'b0, 3'd3);
      drive(0, 0, 0, 0, 0);
      step();
      chk("c_armed_wait", 1'b0, 1'b0, 1'b0, 3'd3);
      drive(0, 1, 0, 0, 0);
      step();
      ring_pattern("c", 3'd3);

      // Reset in the middle of ringing.
      drive(1, 0, 1, 0, 0);
      step();
      drive(0, 1, 0, 0, 0);
      step();
      repeat (5) step();
      chk("d_ringing", 1'b1, 1'b0, 1'b1, 3'd3);
      rst_n = 1'b0;
      step();
      chk("d_reset", 1'b0, 1'b0, 1'b0, 3'd0);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
      step();
      drive(0, 1, 0, 0, 0);
      step();
      chk("d_idle_ignores_tz", 1'b0, 1'b0, 1'b0, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
